// File: rtl/lcb_pkg.sv
// lcb_pkg: shared widths, bank encoding and arbiter state encoding for the LCB write path
package lcb_pkg;
  localparam int LCB_AW = 10;
  localparam int LCB_DW = 12;
  localparam logic BANK_MEM2 = 1'b0;
  localparam logic BANK_MEM1 = 1'b1;
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GUARD} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first request at or after the pointer and returns the pointer past it
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] nxt
);
  localparam int PW = $clog2(N_REQ);
  logic [PW-1:0] idx;
  logic hit;
  always_comb begin
    gnt = '0;
    nxt = ptr;
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = PW'((int'(ptr) + i) % N_REQ);
      if (!hit && req[idx]) begin
        hit = 1'b1;
        gnt[idx] = 1'b1;
        nxt = PW'((int'(idx) + 1) % N_REQ);
      end
    end
  end
endmodule

// File: rtl/lcb_bank_arbiter.sv
// lcb_bank_arbiter: round-robin LCB write arbitration into ping-pong frame buffers with guarded bank swap
module lcb_bank_arbiter import lcb_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int AW = LCB_AW,
  parameter int DW = LCB_DW,
  parameter int GUARD = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                iSwitch,
  input  logic [N_REQ-1:0]    iReq,
  input  logic [N_REQ*AW-1:0] iAddr,
  input  logic [N_REQ*DW-1:0] iData,
  output logic [N_REQ-1:0]    oAck,
  output logic [AW-1:0]       oAddr,
  output logic [DW-1:0]       oData,
  output logic                oMem1We,
  output logic                oMem2We,
  output logic                oBank,
  output logic                oGuard,
  output logic [AW-1:0]       oWrCnt,
  output logic [AW-1:0]       oLastCnt
);
  localparam int PW = $clog2(N_REQ);
  state_t state, state_nxt;
  logic sw_s1, sw_s2, sw_h, swap;
  logic [3:0] gcnt;
  logic guard_done, grant_en, grant, we;
  logic [PW-1:0] ptr, ptr_nxt;
  logic [N_REQ-1:0] gnt;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  assign swap = sw_s2 ^ sw_h;
  assign guard_done = state == ST_GUARD && !swap && gcnt == 4'(GUARD - 1);
  assign grant_en = !reset && state != ST_GUARD && !swap;
  assign grant = |gnt;
  assign oAck = gnt;
  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req(iReq & {N_REQ{grant_en}}),
    .ptr(ptr),
    .gnt(gnt),
    .nxt(ptr_nxt)
  );
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        sel_addr = iAddr[k*AW +: AW];
        sel_data = iData[k*DW +: DW];
      end
    end
  end
  always_ff @(posedge clk) begin
    sw_s1 <= reset ? 1'b0 : iSwitch;
    sw_s2 <= reset ? 1'b0 : sw_s1;
    sw_h <= reset ? 1'b0 : sw_s2;
    gcnt <= (reset || swap || state != ST_GUARD) ? '0 : gcnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    state <= reset ? ST_IDLE : state_nxt;
  end
  always_comb begin
    state_nxt = swap ? ST_GUARD
              : state == ST_GUARD ? (guard_done ? ST_IDLE : ST_GUARD)
              : (|iReq ? ST_GRANT : ST_IDLE);
  end
  always_comb begin
    oGuard = state == ST_GUARD;
    oMem1We = we && oBank == BANK_MEM1;
    oMem2We = we && oBank == BANK_MEM2;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      we <= 1'b0;
      ptr <= '0;
      oAddr <= '0;
      oData <= '0;
      oBank <= BANK_MEM2;
      oWrCnt <= '0;
      oLastCnt <= '0;
    end else begin
      we <= grant;
      if (grant) begin
        ptr <= ptr_nxt;
        oAddr <= sel_addr;
        oData <= sel_data;
        oWrCnt <= &oWrCnt ? oWrCnt : oWrCnt + 1'b1;
      end
      if (guard_done) begin
        oBank <= sw_s2;
        oLastCnt <= oWrCnt;
        oWrCnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_lcb_bank_arbiter.sv
// tb_lcb_bank_arbiter: directed checks of arbitration, bank swap guard, saturation and reset abort
module tb_lcb_bank_arbiter;
  logic clk = 1'b0;
  logic reset, iSwitch;
  logic [3:0] iReq;
  logic [39:0] iAddr;
  logic [47:0] iData;
  logic [3:0] oAck;
  logic [9:0] oAddr;
  logic [11:0] oData;
  logic oMem1We, oMem2We, oBank, oGuard;
  logic [9:0] oWrCnt, oLastCnt;
  int n_cmp = 0;
  int n_bad = 0;
  int acks;
  int order [5] = '{0, 1, 2, 3, 0};
  always #5 clk = ~clk;
  lcb_bank_arbiter dut (
    .clk(clk),
    .reset(reset),
    .iSwitch(iSwitch),
    .iReq(iReq),
    .iAddr(iAddr),
    .iData(iData),
    .oAck(oAck),
    .oAddr(oAddr),
    .oData(oData),
    .oMem1We(oMem1We),
    .oMem2We(oMem2We),
    .oBank(oBank),
    .oGuard(oGuard),
    .oWrCnt(oWrCnt),
    .oLastCnt(oLastCnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rst_pulse();
    reset = 1'b1;
    iReq = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    iSwitch = 1'b0;
    iReq = '0;
    iAddr = '0;
    iData = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_ack", 32'(oAck), 0);
    chk("rst_we", 32'({oMem1We, oMem2We}), 0);
    chk("rst_addr", 32'(oAddr), 0);
    chk("rst_bank", 32'(oBank), 0);
    chk("rst_guard", 32'(oGuard), 0);
    chk("rst_cnt", 32'(oWrCnt), 0);
    tick();
    reset = 1'b0;
    iReq = 4'b0001;
    iAddr[9:0] = 10'h005;
    iData[11:0] = 12'hABC;
    @(negedge clk);
    chk("t1_ack", 32'(oAck), 1);
    tick();
    iReq = '0;
    @(negedge clk);
    chk("t1_addr", 32'(oAddr), 32'h005);
    chk("t1_data", 32'(oData), 32'hABC);
    chk("t1_we2", 32'(oMem2We), 1);
    chk("t1_we1", 32'(oMem1We), 0);
    chk("t1_cnt", 32'(oWrCnt), 1);
    chk("t1_ack_off", 32'(oAck), 0);
    tick();
    @(negedge clk);
    chk("t1_we_off", 32'({oMem1We, oMem2We}), 0);
    rst_pulse();
    for (int k = 0; k < 4; k++) begin
      iAddr[k*10 +: 10] = 10'(16 + k);
      iData[k*12 +: 12] = 12'(256 + k);
    end
    iReq = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_ack", 32'(oAck), 32'(1 << order[i]));
      if (i > 0) begin
        chk("t2_we", 32'(oMem2We), 1);
        chk("t2_addr", 32'(oAddr), 32'(16 + order[i-1]));
      end
      tick();
    end
    iReq = '0;
    @(negedge clk);
    chk("t2_last_addr", 32'(oAddr), 16);
    chk("t2_last_data", 32'(oData), 256);
    chk("t2_last_we", 32'(oMem2We), 1);
    chk("t2_cnt", 32'(oWrCnt), 5);
    chk("t2_ack_off", 32'(oAck), 0);
    tick();
    iSwitch = 1'b1;
    @(negedge clk);
    chk("t3_pre0", 32'(oGuard), 0);
    tick();
    @(negedge clk);
    chk("t3_pre1", 32'(oGuard), 0);
    tick();
    iReq = 4'b0100;
    iAddr[29:20] = 10'h077;
    iData[35:24] = 12'h123;
    @(negedge clk);
    chk("t3_swap_ack", 32'(oAck), 0);
    chk("t3_swap_guard", 32'(oGuard), 0);
    for (int g = 0; g < 4; g++) begin
      tick();
      @(negedge clk);
      chk("t3_guard", 32'(oGuard), 1);
      chk("t3_noack", 32'(oAck), 0);
      chk("t3_oldbank", 32'(oBank), 0);
    end
    tick();
    @(negedge clk);
    chk("t3_exit_guard", 32'(oGuard), 0);
    chk("t3_bank", 32'(oBank), 1);
    chk("t3_last", 32'(oLastCnt), 5);
    chk("t3_cnt_clr", 32'(oWrCnt), 0);
    chk("t3_ack", 32'(oAck), 32'b0100);
    tick();
    iReq = '0;
    @(negedge clk);
    chk("t3_we1", 32'(oMem1We), 1);
    chk("t3_we2", 32'(oMem2We), 0);
    chk("t3_addr", 32'(oAddr), 32'h077);
    chk("t3_data", 32'(oData), 32'h123);
    chk("t3_cnt", 32'(oWrCnt), 1);
    tick();
    iSwitch = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("t4_pre", 32'(oGuard), 0);
    for (int g = 0; g < 7; g++) begin
      tick();
      if (g == 0) iSwitch = 1'b1;
      @(negedge clk);
      chk("t4_guard", 32'(oGuard), 1);
    end
    tick();
    @(negedge clk);
    chk("t4_exit_guard", 32'(oGuard), 0);
    chk("t4_bank", 32'(oBank), 1);
    chk("t4_last", 32'(oLastCnt), 1);
    chk("t4_cnt", 32'(oWrCnt), 0);
    tick();
    iReq = 4'b0001;
    acks = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (oAck == 4'b0001) acks++;
      tick();
    end
    iReq = '0;
    @(negedge clk);
    chk("t5_acks", 32'(acks), 1100);
    chk("t5_sat", 32'(oWrCnt), 1023);
    chk("t5_we1", 32'(oMem1We), 1);
    tick();
    iSwitch = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    chk("t5_last", 32'(oLastCnt), 1023);
    chk("t5_cnt", 32'(oWrCnt), 0);
    chk("t5_bank", 32'(oBank), 0);
    tick();
    iSwitch = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    chk("t6_bank", 32'(oBank), 1);
    tick();
    iReq = 4'b0110;
    iAddr[19:10] = 10'h0AA;
    iData[23:12] = 12'h5A5;
    @(negedge clk);
    chk("t6_ack", 32'(oAck), 32'b0010);
    tick();
    reset = 1'b1;
    iSwitch = 1'b0;
    @(negedge clk);
    chk("t6_we1", 32'(oMem1We), 1);
    chk("t6_ack_rst", 32'(oAck), 0);
    tick();
    @(negedge clk);
    chk("t6_rst_we", 32'({oMem1We, oMem2We}), 0);
    chk("t6_rst_ack", 32'(oAck), 0);
    chk("t6_rst_bank", 32'(oBank), 0);
    chk("t6_rst_addr", 32'(oAddr), 0);
    chk("t6_rst_data", 32'(oData), 0);
    chk("t6_rst_cnt", 32'(oWrCnt), 0);
    chk("t6_rst_last", 32'(oLastCnt), 0);
    chk("t6_rst_guard", 32'(oGuard), 0);
    reset = 1'b0;
    #1;
    chk("t6_first_ack", 32'(oAck), 32'b0010);
    tick();
    iReq = '0;
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
